// File: rtl/sd_pkg.sv
// Shared types and constants for the SD command path.
package sd_pkg;

   localparam int unsigned CMD_FRAME_W = 48;
   localparam int unsigned CRC_IN_W    = 40;
   localparam int unsigned CRC_W       = 7;

   localparam logic START_BIT = 1'b0;
   localparam logic TX_BIT    = 1'b1;
   localparam logic END_BIT   = 1'b1;

   localparam logic [5:0] CMD0  = 6'd0;
   localparam logic [5:0] CMD17 = 6'd17;

   // x^7 + x^3 + 1, with the x^7 term implied
   localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLR,
      ST_LOAD,
      ST_WAIT,
      ST_ARM,
      ST_SHIFT,
      ST_FIN
   } state_t;

   // One serial step of the CRC7 LFSR, message bit entering at the top.
   function automatic logic [CRC_W-1:0] crc7_step(input logic [CRC_W-1:0] crc,
                                                  input logic bit_in);
      logic fb;
      fb = bit_in ^ crc[CRC_W-1];
      return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
   endfunction

endpackage

// File: rtl/crc7.sv
// Bit-serial CRC7 over a DATA_W-bit word; crc_ready rises DATA_W cycles after load.
module crc7
   import sd_pkg::*;
#(
   parameter int unsigned DATA_W = 40
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] data_in,
   output logic              crc_ready,
   output logic [CRC_W-1:0]  crc
);

   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] sh_q;
   logic [CNT_W-1:0]  cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_q      <= '0;
         cnt_q     <= '0;
         crc       <= '0;
         crc_ready <= 1'b0;
      end else if (load) begin
         sh_q      <= data_in;
         cnt_q     <= CNT_W'(DATA_W);
         crc       <= '0;
         crc_ready <= 1'b0;
      end else if (cnt_q != '0) begin
         crc       <= crc7_step(crc, sh_q[DATA_W-1]);
         sh_q      <= sh_q << 1;
         cnt_q     <= cnt_q - CNT_W'(1);
         crc_ready <= (cnt_q == CNT_W'(1));
      end
   end

endmodule

// File: rtl/sd_cmd_tx.sv
// SD command sequencer: builds the 48-bit command frame with CRC7 and shifts it
// MSB-first onto the CMD line, one bit per tx_tick.
module sd_cmd_tx
   import sd_pkg::*;
#(
   parameter int unsigned CRC_TIMEOUT = 63,
   parameter int unsigned FRAME_BITS  = CMD_FRAME_W
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [5:0]  cmd_index,
   input  logic [31:0] cmd_arg,
   input  logic        tx_tick,
   output logic        cmd_out,
   output logic        cmd_oe,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int unsigned TMO_W = $clog2(CRC_TIMEOUT + 1);
   localparam int unsigned BIT_W = $clog2(FRAME_BITS);
   localparam int unsigned MSB   = CMD_FRAME_W - 1;
   // error is registered, so the compare fires one cycle early to land
   // exactly CRC_TIMEOUT cycles after LOAD
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CRC_TIMEOUT - 2);

   state_t                 state_q, state_d;
   logic [CMD_FRAME_W-1:0] frame_q, frame_d;
   logic [TMO_W-1:0]       tmo_q, tmo_d;
   logic [BIT_W-1:0]       bit_q, bit_d;
   logic                   out_d, oe_d, done_d, error_d;
   logic                   crc_clr;
   logic                   crc_rst_c;
   logic                   crc_load_c;
   logic                   crc_ready;
   logic [CRC_W-1:0]       crc;

   assign crc_rst_c  = reset | crc_clr;
   assign crc_load_c = (state_q == ST_LOAD);

   crc7 #(.DATA_W(CRC_IN_W)) u_crc7 (
      .clk       (clk),
      .reset     (crc_rst_c),
      .load      (crc_load_c),
      .data_in   (frame_q[MSB -: CRC_IN_W]),
      .crc_ready (crc_ready),
      .crc       (crc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         frame_q   <= '0;
         tmo_q     <= '0;
         bit_q     <= '0;
         cmd_ready <= 1'b1;
         cmd_out   <= 1'b1;
         cmd_oe    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         crc_clr   <= 1'b0;
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         tmo_q     <= tmo_d;
         bit_q     <= bit_d;
         cmd_ready <= (state_d == ST_IDLE);
         cmd_out   <= out_d;
         cmd_oe    <= oe_d;
         busy      <= (state_d != ST_IDLE);
         done      <= done_d;
         error     <= error_d;
         crc_clr   <= (state_d == ST_CLR);
      end
   end

   // Next-state and next-output decode
   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      tmo_d   = tmo_q;
      bit_d   = bit_q;
      out_d   = cmd_out;
      oe_d    = cmd_oe;
      done_d  = 1'b0;
      error_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               frame_d = {START_BIT, TX_BIT, cmd_index, cmd_arg, 8'h00};
               state_d = ST_CLR;
            end
         end
         ST_CLR: state_d = ST_LOAD;
         ST_LOAD: begin
            tmo_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            tmo_d = tmo_q + TMO_W'(1);
            if (crc_ready) begin
               frame_d[7:0] = {crc, END_BIT};
               state_d      = ST_ARM;
            end else if (tmo_q == TMO_LAST) begin
               error_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_ARM: begin
            if (tx_tick) begin
               oe_d    = 1'b1;
               out_d   = frame_q[MSB];
               bit_d   = BIT_W'(FRAME_BITS - 1);
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (tx_tick) begin
               if (bit_q == '0) begin
                  oe_d    = 1'b0;
                  out_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = ST_FIN;
               end else begin
                  frame_d = frame_q << 1;
                  out_d   = frame_q[MSB-1];
                  bit_d   = bit_q - BIT_W'(1);
               end
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: doc/sd_cmd_tx.md
Name: sd_cmd_tx

Overview:
Command-path sequencer for the SD host. It accepts a 6-bit command index and a 32-bit argument, and builds the 40-bit CRC input (start 0, transmission 1, index, argument). It drives the crc7 engine through clear, load and wait, then assembles the 48-bit frame (40 bits plus CRC7 plus end bit 1) and shifts it MSB-first onto the CMD line, one bit per SD-clock tick.

Parameters:
CRC_TIMEOUT, 63, maximum clk cycles to wait for crc_ready after load before aborting with error.
FRAME_BITS, 48, command frame length. Fixed by the SD spec; exposed for the bench only.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
cmd_valid  in  1  command request. Held until accepted.
cmd_ready  out  1  high in IDLE only. A transfer occurs when cmd_valid and cmd_ready are both high.
cmd_index  in  6  command index, sampled on transfer.
cmd_arg  in  32  argument, sampled on transfer.
tx_tick  in  1  one-cycle strobe from the SD clock divider, marking each CMD-line bit boundary.
cmd_out  out  1  serial CMD line data.
cmd_oe  out  1  CMD line output enable.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse after the end bit completes.
error  out  1  one-cycle pulse on CRC timeout.

Behaviour:
- Reset (async) puts the block in IDLE with cmd_ready=1, cmd_out=1, cmd_oe=0, busy=0, done=0, error=0, shift register cleared, counters 0. The crc7 reset is tied to reset.
- States: IDLE, CLR, LOAD, WAIT, ARM, SHIFT, FIN.
- IDLE: on transfer, latch frame[47:8] = {1'b0, 1'b1, cmd_index, cmd_arg} and go to CLR.
- CLR (1 cycle): assert crc_clr; the crc7 reset input is reset | crc_clr. Go to LOAD.
- LOAD (1 cycle): drive crc7 load=1 with data_in=frame[47:8]. Clear the timeout counter. Go to WAIT.
- WAIT: the counter increments each cycle.
  - crc_ready=1: latch frame[7:1]=crc and frame[0]=1, then go to ARM.
  - Counter reaches CRC_TIMEOUT: pulse error and go to IDLE. cmd_oe stays 0 and nothing is driven on the line.
- ARM: wait for tx_tick. On the first tick, assert cmd_oe, drive cmd_out=frame[47], set bit counter=47, and go to SHIFT.
- SHIFT: each tx_tick shifts left one bit and decrements the counter; cmd_out always presents the current MSB. Between ticks cmd_out is stable. The tick that would move past bit 0 goes to FIN.
- FIN (1 cycle): cmd_oe=0, cmd_out=1, pulse done, return to IDLE. cmd_ready is high the following cycle.
- The line carries exactly 48 bits. Each bit is held for one full tick interval. The first bit is aligned to a tick.
- cmd_valid while busy is ignored: cmd_ready=0, inputs not sampled.
- tx_tick outside ARM and SHIFT is ignored.
- Reset asserted mid-frame: immediate release of the line (cmd_oe=0, cmd_out=1) and the crc7 engine reset. No done or error pulse.
- done and error are never asserted in the same cycle.

Decomposition:
- Shared package sd_pkg holds:
  - state encoding;
  - localparams START_BIT=0, TX_BIT=1, END_BIT=1;
  - CMD_FRAME_W=48, CRC_IN_W=40;
  - command index constants CMD0=6'd0 and CMD17=6'd17.
- One sub-module: crc7 #(40), instantiated internally (port names clk, reset, load, data_in, crc_ready, crc).
- No other hierarchy.

Test Plan:
- CMD0, arg 0x00000000, tx_tick every 4 clk -> 48 bits on cmd_out = 0x40_0000_0000_95 (CRC 1001010). done pulses once. cmd_oe is high for exactly 48 tick intervals.
- CMD17, arg 0x00000000, tx_tick every 8 clk -> frame 0x51_0000_0000_55 (CRC 0101010). The bench checks that cmd_out changes only on tick cycles.
- Back-to-back: CMD0 followed by CMD17 with cmd_valid held -> cmd_ready=0 throughout the first frame. The second frame starts only after done. Both frames are correct, proving the crc7 clear between commands.
- Reset pulsed at bit 20 of CMD17 -> cmd_oe=0 and cmd_out=1 asynchronously, no done. A following CMD0 completes correctly.
- Timeout: hierarchically force the internal crc_ready=0, issue CMD0 -> error pulses exactly CRC_TIMEOUT cycles after LOAD, cmd_oe never rises, cmd_ready returns high.
- Idle ticks: tx_tick toggling in IDLE with no cmd_valid -> cmd_out=1, cmd_oe=0, busy=0 throughout.
